// File: rtl/tdm_demux4.sv
// Four-slot TDM receiver: hunts for frame_sync, then routes samples into shadow
// registers and publishes all four channels together on each completed frame.
// Optional saturating sync-error counter enabled by defining TDM_DEMUX_ERRCNT_EN.
module tdm_demux4 #(
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              frame_sync,
    output logic [DATA_W-1:0] Y0,
    output logic [DATA_W-1:0] Y1,
    output logic [DATA_W-1:0] Y2,
    output logic [DATA_W-1:0] Y3,
    output logic              frame_valid,
    output logic              locked,
    output logic [1:0]        slot,
`ifdef TDM_DEMUX_ERRCNT_EN
    output logic [7:0]        err_cnt,
`endif
    output logic              sync_err
);

    typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

    state_t            state_r, state_s;
    logic [1:0]        slot_r, slot_s;
    logic [DATA_W-1:0] shadow0_r, shadow1_r, shadow2_r;
    logic [DATA_W-1:0] shadow0_s, shadow1_s, shadow2_s;
    logic [DATA_W-1:0] y0_r, y1_r, y2_r, y3_r;
    logic [DATA_W-1:0] y0_s, y1_s, y2_s, y3_s;
    logic              frame_valid_r, frame_valid_s;
    logic              sync_err_r, sync_err_s;

    // State, slot counter, shadow and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= HUNT;
            slot_r        <= 2'd0;
            shadow0_r     <= {DATA_W{1'b0}};
            shadow1_r     <= {DATA_W{1'b0}};
            shadow2_r     <= {DATA_W{1'b0}};
            y0_r          <= {DATA_W{1'b0}};
            y1_r          <= {DATA_W{1'b0}};
            y2_r          <= {DATA_W{1'b0}};
            y3_r          <= {DATA_W{1'b0}};
            frame_valid_r <= 1'b0;
            sync_err_r    <= 1'b0;
        end else begin
            state_r       <= state_s;
            slot_r        <= slot_s;
            shadow0_r     <= shadow0_s;
            shadow1_r     <= shadow1_s;
            shadow2_r     <= shadow2_s;
            y0_r          <= y0_s;
            y1_r          <= y1_s;
            y2_r          <= y2_s;
            y3_r          <= y3_s;
            frame_valid_r <= frame_valid_s;
            sync_err_r    <= sync_err_s;
        end
    end

    // Next-state decode: idle cycles hold everything, pulses default low
    always_comb begin
        state_s       = state_r;
        slot_s        = slot_r;
        shadow0_s     = shadow0_r;
        shadow1_s     = shadow1_r;
        shadow2_s     = shadow2_r;
        y0_s          = y0_r;
        y1_s          = y1_r;
        y2_s          = y2_r;
        y3_s          = y3_r;
        frame_valid_s = 1'b0;
        sync_err_s    = 1'b0;
        if (din_valid) begin
            case (state_r)
                HUNT: begin
                    if (frame_sync) begin
                        shadow0_s = din;
                        slot_s    = 2'd1;
                        state_s   = LOCK;
                    end else begin
                        slot_s    = 2'd0;
                    end
                end
                LOCK: begin
                    if (frame_sync && (slot_r != 2'd0)) begin
                        // Early marker: drop the partial frame and restart on this beat
                        sync_err_s = 1'b1;
                        shadow0_s  = din;
                        slot_s     = 2'd1;
                    end else if (!frame_sync && (slot_r == 2'd0)) begin
                        sync_err_s = 1'b1;
                        slot_s     = 2'd0;
                        state_s    = HUNT;
                    end else begin
                        case (slot_r)
                            2'd0: shadow0_s = din;
                            2'd1: shadow1_s = din;
                            2'd2: shadow2_s = din;
                            2'd3: begin
                                y0_s          = shadow0_r;
                                y1_s          = shadow1_r;
                                y2_s          = shadow2_r;
                                y3_s          = din;
                                frame_valid_s = 1'b1;
                            end
                            default: shadow0_s = shadow0_r;
                        endcase
                        slot_s = slot_r + 2'd1;
                    end
                end
                default: begin
                    state_s = HUNT;
                    slot_s  = 2'd0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

`ifdef TDM_DEMUX_ERRCNT_EN
    logic [7:0] err_cnt_r;

    // Saturating count of sync_err pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_r <= 8'd0;
        end else if (sync_err_s && (err_cnt_r != 8'd255)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign err_cnt = err_cnt_r;
`endif

    assign Y0          = y0_r;
    assign Y1          = y1_r;
    assign Y2          = y2_r;
    assign Y3          = y3_r;
    assign frame_valid = frame_valid_r;
    assign sync_err    = sync_err_r;
    assign locked      = (state_r == LOCK);
    assign slot        = slot_r;

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive-side counterpart of the 4-input select mux.
- Accepts a time-division-multiplexed stream of one sample per slot, four slots per frame, with a frame marker on slot 0.
- Routes each sample into a per-channel register and presents the four channels in parallel, updated together once per complete frame.
- Sits at the receiving end of a serialised link that carries the four mux inputs over one wire/bus.

Parameters:
DATA_W, 1, width of each sample and of each channel output

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
din  input  DATA_W  sample for the current slot
din_valid  input  1  din/frame_sync valid this cycle (one slot consumed per valid cycle)
frame_sync  input  1  qualifies din as slot 0 of a frame; ignored when din_valid=0
Y0  output  DATA_W  channel 0 (slot 0), registered
Y1  output  DATA_W  channel 1 (slot 1), registered
Y2  output  DATA_W  channel 2 (slot 2), registered
Y3  output  DATA_W  channel 3 (slot 3), registered
frame_valid  output  1  one-cycle pulse, Y0..Y3 just updated with a complete frame
locked  output  1  1 when in LOCK state
slot  output  2  index of the next slot expected
sync_err  output  1  one-cycle pulse on framing violation

Behaviour:
- Clock is clk; reset is rst, asynchronous and active-high. On rst: state=HUNT, slot=0, Y0..Y3=0, shadow regs=0, frame_valid=0, sync_err=0, locked=0.
- All outputs are registered.
- The counter advances only on cycles with din_valid=1. Idle gaps of any length are allowed and hold all state.
- HUNT:
  - din_valid & frame_sync: shadow0<=din, slot<=1, go LOCK.
  - Any other valid beat is discarded silently (no sync_err).
- LOCK, on din_valid:
  - frame_sync=1 and slot!=0: sync_err pulse; partial frame discarded; beat taken as slot 0 (shadow0<=din, slot<=1); stay LOCK.
  - frame_sync=0 and slot==0: sync_err pulse; beat discarded; slot<=0; go HUNT.
  - Otherwise: capture into shadow[slot], slot<=slot+1, mod 4 (3 wraps to 0).
- Slot 3 capture (valid, no violation):
  - On that same edge: Y0<=shadow0, Y1<=shadow1, Y2<=shadow2, Y3<=din; frame_valid<=1.
  - Latency: new Y values and the frame_valid pulse appear in the cycle after the slot-3 beat.
  - Y0..Y3 never change except on a frame completion or on reset.
- frame_valid and sync_err are each exactly one cycle wide.
- Back-to-back frames (four consecutive valid beats per frame, no gaps) give a frame_valid pulse every 4th cycle.
- Reset mid-frame discards the partial frame and forces HUNT. Y returns to 0.

Optional Feature:
- Macro TDM_DEMUX_ERRCNT_EN.
- When defined: adds output err_cnt [7:0]. Reset 0. Increments by 1 on each sync_err pulse and saturates at 255 (no wrap).
- When undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then valid beats with frame_sync on the first and din=1,0,1,1 (DATA_W=1) -> locked=1 after beat 1; cycle after beat 4: Y0..Y3=1,0,1,1 and frame_valid=1 for exactly one cycle.
- Same frame with din_valid low for 3 cycles between each beat -> identical Y values, single frame_valid pulse, slot holds during gaps.
- Two back-to-back frames 1,1,0,0 then 0,1,1,0 -> frame_valid pulses 4 cycles apart; Y shows 1,1,0,0 then 0,1,1,0; Y unchanged between pulses.
- frame_sync asserted on slot 2 of a locked frame -> sync_err pulse, no frame_valid; next three beats complete a frame starting from that beat.
- Valid beat without frame_sync while slot=0 in LOCK -> sync_err pulse, locked=0; next frame_sync beat relocks. With TDM_DEMUX_ERRCNT_EN, 300 forced errors -> err_cnt=255.
- Assert rst after slot 2 captured -> Y0..Y3=0, locked=0, slot=0 immediately (async); no frame_valid.
